writeback_unit: RTL and testbench

//   Write-port master for register_file: queues results from execute/memory, retires one per cycle onto A3/WD3/WE3.

---
 rtl/writeback_unit.sv | 178 +++++++++++++++++
 tb/tb_writeback_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Result writeback: queues execute/memory results and retires one per cycle to register_file.
// A retiring R15 write becomes a PC redirect. Define WB_BYPASS_EN to build the queue bypass search.
module writeback_unit #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wen,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_fwen,
  input  logic [3:0]        in_flags,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic [3:0]        flags,
  output logic              busy,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(15);

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic              wen;
    logic [DATA_W-1:0] result;
    logic              fwen;
    logic [3:0]        flags;
  } entry_t;

  typedef enum logic {RUN, REDIRECT} state_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d, pct_q, pct_d;
  logic              we3_q, we3_d;
  logic [3:0]        flags_q, flags_d;

  entry_t head;
  logic   empty, full, pop, push, redir;

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign pop   = !empty;
  assign redir = pop && head.wen && (head.dest == PC_REG);
  // Ready looks only at registered state, so the sender's valid never loops back into it.
  assign in_ready = !full && !redir;
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    we3_d    = 1'b0;
    pct_d    = pct_q;
    flags_d  = flags_q;
    case (state_q)
      RUN:      if (redir) state_d = REDIRECT;
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (redir) begin
      // Everything younger than the PC write is on the wrong path: drop it.
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
      pct_d    = head.result & ~DATA_W'(3);
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (pop && head.wen) begin
        a3_d  = head.dest;
        wd3_d = head.result;
        we3_d = 1'b1;
      end
    end
    if (pop && head.fwen) flags_d = head.flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      a3_q     <= '0;
      wd3_q    <= '0;
      we3_q    <= 1'b0;
      pct_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      we3_q    <= we3_d;
      pct_q    <= pct_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{dest: in_dest, wen: in_wen, result: in_result,
                                   fwen: in_fwen, flags: in_flags};
  end

  assign A3        = a3_q;
  assign WD3       = wd3_q;
  assign WE3       = we3_q;
  assign pc_load   = (state_q == REDIRECT);
  assign pc_target = pct_q;
  assign flags     = flags_q;
  assign busy      = !empty;

`ifdef WB_BYPASS_EN
  logic [1:0][ADDR_W-1:0] qa;
  logic [1:0]             hit;
  logic [1:0][DATA_W-1:0] bdat;
  logic [PW-1:0]          bidx;

  assign qa = {q_addr2, q_addr1};

  // Scan oldest to youngest (retiring stage first) so the last match wins.
  always_comb begin
    hit  = '0;
    bdat = '0;
    bidx = '0;
    for (int p = 0; p < 2; p++) begin
      if (we3_q && (a3_q == qa[p])) begin
        hit[p]  = 1'b1;
        bdat[p] = wd3_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        bidx = rd_ptr_q + PW'(k);
        if ((CW'(k) < cnt_q) && mem_q[bidx].wen && (mem_q[bidx].dest == qa[p]) &&
            (mem_q[bidx].dest != PC_REG)) begin
          hit[p]  = 1'b1;
          bdat[p] = mem_q[bidx].result;
        end
      end
    end
  end

  assign byp_hit1  = hit[0];
  assign byp_hit2  = hit[1];
  assign byp_data1 = bdat[0];
  assign byp_data2 = bdat[1];
`else
  logic unused_q;
  assign unused_q  = ^{q_addr1, q_addr2};
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: retire latency, ordering, R15 redirect, flags, reset, bypass.
module tb_writeback_unit;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid, in_ready, in_wen, in_fwen;
  logic [ADDR_W-1:0] in_dest, A3, q_addr1, q_addr2;
  logic [DATA_W-1:0] in_result, WD3, pc_target, byp_data1, byp_data2;
  logic [3:0]        in_flags, flags;
  logic              WE3, pc_load, busy, byp_hit1, byp_hit2;

  int n_chk  = 0;
  int n_fail = 0;

  writeback_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
    .in_wen(in_wen), .in_result(in_result), .in_fwen(in_fwen), .in_flags(in_flags),
    .A3(A3), .WD3(WD3), .WE3(WE3), .pc_load(pc_load), .pc_target(pc_target),
    .flags(flags), .busy(busy), .q_addr1(q_addr1), .q_addr2(q_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] d, input logic w,
                       input logic [DATA_W-1:0] r, input logic fw, input logic [3:0] f);
    in_valid  = v;
    in_dest   = d;
    in_wen    = w;
    in_result = r;
    in_fwen   = fw;
    in_flags  = f;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 4'h0);
  endtask

  logic [ADDR_W-1:0] dl [5] = '{9'd5, 9'd6, 9'd7, 9'd20, 9'd9};
  int  sent, got;
  logic acc, r2w;

  initial begin
    idle();
    q_addr1 = '0;
    q_addr2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_we3", WE3, 0);
    check("rst_a3", A3, 0);
    check("rst_wd3", WD3, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_flags", flags, 0);
    check("rst_pcload", pc_load, 0);
    check("rst_pctgt", pc_target, 0);
    check("rst_byp", {byp_hit1, byp_hit2, byp_data1 | byp_data2}, 0);

    // single result: two edges to WE3
    drive(1'b1, 9'd3, 1'b1, 32'hDEADBEEF, 1'b0, 4'h0);
    @(negedge clk);
    idle();
    check("t1_busy", busy, 1);
    check("t1_we3_early", WE3, 0);
    @(negedge clk);
    check("t1_we3", WE3, 1);
    check("t1_a3", A3, 3);
    check("t1_wd3", WD3, 32'hDEADBEEF);
    check("t1_busy_after", busy, 0);
    @(negedge clk);
    check("t1_we3_pulse", WE3, 0);

    // five back-to-back, includes dest>=16
    sent = 0; got = 0; acc = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (acc) sent++;
      if (WE3) begin
        if (got < 5) begin
          check("t2_a3", A3, dl[got]);
          check("t2_wd3", WD3, 32'h100 + got);
        end
        got++;
      end
      if (sent < 5) drive(1'b1, dl[sent], 1'b1, 32'h100 + sent, 1'b0, 4'h0);
      else idle();
      acc = in_valid && in_ready;
    end
    check("t2_count", got, 5);
    check("t2_busy", busy, 0);

    // R15 redirect
    drive(1'b1, 9'd1, 1'b1, 32'h11, 1'b0, 4'h0);
    @(negedge clk);
    drive(1'b1, 9'd15, 1'b1, 32'h103, 1'b0, 4'h0);
    @(negedge clk);
    check("t3_r1_we3", WE3, 1);
    check("t3_r1_a3", A3, 1);
    check("t3_pcload_early", pc_load, 0);
    drive(1'b1, 9'd2, 1'b1, 32'h22, 1'b0, 4'h0);
    check("t3_ready_low", in_ready, 0);
    @(negedge clk);
    idle();
    check("t3_pcload", pc_load, 1);
    check("t3_pctgt", pc_target, 32'h100);
    check("t3_we3", WE3, 0);
    check("t3_busy", busy, 0);
    r2w = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("t3_pcload_pulse", pc_load, 0);
      if (WE3 && A3 == 9'd2) r2w = 1'b1;
    end
    check("t3_r2_never", r2w, 0);

    // flags-only result
    drive(1'b1, 9'd7, 1'b0, 32'h55, 1'b1, 4'b1010);
    @(negedge clk);
    idle();
    check("t4_flags_before", flags, 0);
    @(negedge clk);
    check("t4_we3", WE3, 0);
    check("t4_flags", flags, 4'b1010);

    // reset with work in flight
    drive(1'b1, 9'd8, 1'b1, 32'h1, 1'b1, 4'b0110);
    @(negedge clk);
    drive(1'b1, 9'd9, 1'b1, 32'h2, 1'b0, 4'h0);
    @(negedge clk);
    drive(1'b1, 9'd10, 1'b1, 32'h3, 1'b0, 4'h0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("t5_we3", WE3, 0);
    check("t5_busy", busy, 0);
    check("t5_flags", flags, 0);
    check("t5_pcload", pc_load, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_we3_after", WE3, 0);
    check("t5_ready", in_ready, 1);

    // bypass: older r4 in retire stage, younger r4 queued
    q_addr1 = 9'd4;
    q_addr2 = 9'd15;
    drive(1'b1, 9'd4, 1'b1, 32'h11, 1'b0, 4'h0);
    @(negedge clk);
    drive(1'b1, 9'd4, 1'b1, 32'h22, 1'b0, 4'h0);
    @(negedge clk);
    idle();
`ifdef WB_BYPASS_EN
    check("t6_hit1", byp_hit1, 1);
    check("t6_data1", byp_data1, 32'h22);
    check("t6_hit2", byp_hit2, 0);
    @(negedge clk);
    check("t6_hit1_stage", byp_hit1, 1);
    check("t6_data1_stage", byp_data1, 32'h22);
`else
    check("t6_hit1_off", byp_hit1, 0);
    check("t6_data1_off", byp_data1, 0);
    check("t6_hit2_off", byp_hit2, 0);
    @(negedge clk);
    check("t6_data2_off", byp_data2, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
